debug_step_controller: RTL and testbench
========================================

# debug_step_controller

Sequencer for the pipeline's debug-control inputs. It decodes host commands (run, step, clear) from the UART receive path and drives the shared `pipe_enable` / `pipe_reset` lines into every inter-stage pipeline register. It detects end-of-program from the writeback stage and handshakes a register/memory dump with the debug transmitter after every stop. It sits between the UART command decoder and the datapath pipeline registers.

## Interface
Parameters:
- `MAX_CYCLES`, default 32'd100000: watchdog limit on enabled cycles per run. Used only when the watchdog is compiled in.

Ports:
- `clock`, in, 1: system clock. Controller logic uses the rising edge.
- `reset`, in, 1: reset, asynchronous, active-high.
- `cmd_valid`, in, 1: command byte present.
- `cmd_code`, in, 8: command byte.
- `cmd_ready`, out, 1: controller accepts a command this cycle.
- `eop_wb`, in, 1: end-of-program flag at the output of the last pipeline register.
- `pipe_enable`, out, 1: advance enable to all pipeline registers.
- `pipe_reset`, out, 1: synchronous flush to all pipeline registers.
- `dump_start`, out, 1: one-cycle request to the dump transmitter.
- `dump_done`, in, 1: dump transmitter finished.
- `cycle_count`, out, 32: number of enabled cycles since the last clear.
- `state_out`, out, 3: current state encoding, for status LEDs and the host.
- `eop_seen`, out, 1: program end reached.
- `timeout`, out, 1: watchdog stopped the run.

## Operation
- Commands:
  - CMD_RUN = 8'h63.
  - CMD_STEP = 8'h73.
  - CMD_CLEAR = 8'h78.
  - Any other code is accepted and discarded with no effect.
- A command is accepted on a rising edge where `cmd_valid` and `cmd_ready` are both high.
- `cmd_ready` is combinational from state: 1 in IDLE and DONE, 0 otherwise.
- States:
  - IDLE=0
  - RUN=1
  - STEP=2
  - DUMP=3
  - DONE=4
- IDLE:
  - CMD_RUN goes to RUN.
  - CMD_STEP goes to STEP.
  - CMD_CLEAR stays in IDLE and performs a clear.
- RUN:
  - `pipe_enable`=1 in every cycle.
  - Each rising edge with `pipe_enable`=1 increments `cycle_count`, wrapping mod 2^32.
  - `eop_wb`=1 at a rising edge: `pipe_enable`<=0, `eop_seen`<=1, go to DUMP.
- STEP:
  - `pipe_enable`=1 for exactly one cycle.
  - At the next edge: increment the count, `eop_seen`<=`eop_wb`, go to DUMP.
- DUMP:
  - `dump_start`=1 only in the first cycle of DUMP.
  - `pipe_enable`=0 throughout.
  - `dump_done` sampled high at any edge in DUMP (including the first) goes to DONE if `eop_seen` or `timeout` is set, else to IDLE.
- DONE:
  - Only CMD_CLEAR has an effect: it performs a clear and goes to IDLE.
  - CMD_RUN and CMD_STEP are accepted and dropped.
- Clear:
  - `pipe_reset`=1 for exactly one cycle.
  - `pipe_enable`=0 in that cycle.
  - `cycle_count`, `eop_seen` and `timeout` all go to 0.
- `pipe_enable` and `pipe_reset` are never both 1.
- `cmd_valid` in states other than IDLE and DONE is ignored, not queued.

## Timing
- All outputs except `cmd_ready` are registered.
- The pipeline registers capture on the falling edge. Controller outputs change on the rising edge, which gives half a cycle of setup.
- RUN accepted at edge k: `pipe_enable`=1 from edge k. If `eop_wb` is first high at edge k+n, then `pipe_enable` falls at edge k+n and `cycle_count`=n.
- STEP accepted at edge k: `pipe_enable` is high from edge k to edge k+1, exactly one pipeline advance. `dump_start` is high from edge k+1 to edge k+2.
- Minimum step-to-step turnaround is 3 cycles, with `dump_done` returned in the first DUMP cycle.
- Reset values:
  - state IDLE
  - `cmd_ready`=1
  - `pipe_enable`=0
  - `pipe_reset`=0
  - `dump_start`=0
  - `cycle_count`=0
  - `state_out`=0
  - `eop_seen`=0
  - `timeout`=0
- Reset asserted mid-RUN or mid-DUMP drops `pipe_enable` and `dump_start` immediately, without waiting for a clock edge. A `dump_done` still pending from that dump is ignored once back in IDLE.
- `eop_wb` and the watchdog limit occurring at the same edge: `eop_seen`=1 and `timeout`=0. Program end has priority.

## Configuration
- `DEBUG_CTRL_WATCHDOG_EN` defined:
  - In RUN, an increment that makes `cycle_count` equal `MAX_CYCLES` while `eop_wb`=0 stops the run exactly like program end.
  - `timeout`<=1, go to DUMP, then DONE.
- Not defined: `timeout` is tied to 0, there is no compare logic, and RUN is unbounded.

## Structure
- Package `debug_ctrl_pkg` holds:
  - the state encodings IDLE through DONE,
  - CMD_RUN, CMD_STEP and CMD_CLEAR,
  - the 32-bit counter width constant.
- One sub-module, `debug_cycle_counter`:
  - inputs: increment, clear;
  - output: `cycle_count`;
  - contains the watchdog compare under `DEBUG_CTRL_WATCHDOG_EN`, giving a one-bit `limit_hit` output.
- The top level holds the FSM and the output registers.

## Test plan
- STEP from IDLE with `eop_wb`=0 and `dump_done` returned 2 cycles after `dump_start`:
  - exactly one `pipe_enable` cycle,
  - `cycle_count`=1,
  - back in IDLE with `cmd_ready`=1.
- RUN with `eop_wb` first rising at the 7th enabled edge:
  - `pipe_enable` high for 7 cycles,
  - `cycle_count`=7, `eop_seen`=1,
  - DONE after `dump_done`.
- In DONE, send CMD_RUN and then CMD_CLEAR:
  - RUN is ignored;
  - CLEAR produces a one-cycle `pipe_reset` with `cycle_count`=0 and IDLE.
- With `DEBUG_CTRL_WATCHDOG_EN` and `MAX_CYCLES`=10, RUN with `eop_wb` held 0:
  - stops after 10 enabled cycles,
  - `timeout`=1,
  - DONE after `dump_done`.
- Assert `reset` mid-RUN at count 4:
  - all outputs go to their reset values asynchronously;
  - a `cmd_valid` byte 8'h41 afterwards is accepted with no state change.

Source files
------------

// File: rtl/debug_ctrl_pkg.sv
// Shared encodings for the debug step controller: FSM states, host command
// bytes and the cycle counter width.
package debug_ctrl_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_DUMP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] CMD_RUN   = 8'h63;
    localparam logic [7:0] CMD_STEP  = 8'h73;
    localparam logic [7:0] CMD_CLEAR = 8'h78;

endpackage

// File: rtl/debug_cycle_counter.sv
// Enabled-cycle counter for the debug controller. The watchdog compare exists
// only when DEBUG_CTRL_WATCHDOG_EN is defined; otherwise limit_hit is tied low.
module debug_cycle_counter
    import debug_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX_CYCLES = 32'd100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    input  logic             clear,
    output logic [CNT_W-1:0] cycle_count,
    output logic             limit_hit
);

    localparam logic [CNT_W-1:0] ONE = 1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (clear) begin
            cycle_count <= '0;
        end else if (increment) begin
            cycle_count <= cycle_count + ONE;
        end
    end

`ifdef DEBUG_CTRL_WATCHDOG_EN
    // Flags the edge whose increment lands exactly on the limit.
    assign limit_hit = increment && ((cycle_count + ONE) == MAX_CYCLES);
`else
    assign limit_hit = 1'b0 & (MAX_CYCLES == '0);
`endif

endmodule

// File: rtl/debug_step_controller.sv
// Debug run/step/clear sequencer driving pipe_enable/pipe_reset and the dump
// handshake. Optional run watchdog: define DEBUG_CTRL_WATCHDOG_EN.
module debug_step_controller
    import debug_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX_CYCLES = 32'd100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_code,
    output logic             cmd_ready,
    input  logic             eop_wb,
    output logic             pipe_enable,
    output logic             pipe_reset,
    output logic             dump_start,
    input  logic             dump_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state_out,
    output logic             eop_seen,
    output logic             timeout
);

    state_t state;
    logic   cmd_take;
    logic   do_clear;
    logic   limit_hit;

    assign cmd_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign cmd_take  = cmd_valid && cmd_ready;
    assign do_clear  = cmd_take && (cmd_code == CMD_CLEAR);
    assign state_out = state;

    debug_cycle_counter #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_counter (
        .clock       (clock),
        .reset       (reset),
        .increment   (pipe_enable),
        .clear       (do_clear),
        .cycle_count (cycle_count),
        .limit_hit   (limit_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pipe_enable <= 1'b0;
            pipe_reset  <= 1'b0;
            dump_start  <= 1'b0;
            eop_seen    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            pipe_reset <= 1'b0;
            dump_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_take) begin
                        case (cmd_code)
                            CMD_RUN: begin
                                state       <= ST_RUN;
                                pipe_enable <= 1'b1;
                            end
                            CMD_STEP: begin
                                state       <= ST_STEP;
                                pipe_enable <= 1'b1;
                            end
                            CMD_CLEAR: begin
                                pipe_reset <= 1'b1;
                                eop_seen   <= 1'b0;
                                timeout    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // Program end wins over a watchdog hit on the same edge.
                    if (eop_wb) begin
                        pipe_enable <= 1'b0;
                        eop_seen    <= 1'b1;
                        dump_start  <= 1'b1;
                        state       <= ST_DUMP;
                    end else if (limit_hit) begin
                        pipe_enable <= 1'b0;
                        timeout     <= 1'b1;
                        dump_start  <= 1'b1;
                        state       <= ST_DUMP;
                    end
                end
                ST_STEP: begin
                    pipe_enable <= 1'b0;
                    eop_seen    <= eop_wb;
                    dump_start  <= 1'b1;
                    state       <= ST_DUMP;
                end
                ST_DUMP: begin
                    if (dump_done) begin
                        state <= (eop_seen || timeout) ? ST_DONE : ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (do_clear) begin
                        pipe_reset <= 1'b1;
                        eop_seen   <= 1'b0;
                        timeout    <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    pipe_enable <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_step_controller.sv
// Directed plus randomized bench for debug_step_controller against a
// transaction-level model of runs, steps, dumps and clears.
module tb_debug_step_controller;
    import debug_ctrl_pkg::*;

`ifdef DEBUG_CTRL_WATCHDOG_EN
    localparam logic [31:0] MAXP = 32'd10;
`else
    localparam logic [31:0] MAXP = 32'd100000;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_code = 8'h00;
    logic        eop_wb = 1'b0;
    logic        dump_done = 1'b0;
    logic        cmd_ready;
    logic        pipe_enable;
    logic        pipe_reset;
    logic        dump_start;
    logic [31:0] cycle_count;
    logic [2:0]  state_out;
    logic        eop_seen;
    logic        timeout;

    int tests = 0;
    int failed = 0;

    logic [31:0] m_count = 0;
    logic        m_eop = 0;
    logic        m_timeout = 0;
    logic [2:0]  m_state = 0;

    always #5 clock = ~clock;

    debug_step_controller #(.MAX_CYCLES(MAXP)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_ready   (cmd_ready),
        .eop_wb      (eop_wb),
        .pipe_enable (pipe_enable),
        .pipe_reset  (pipe_reset),
        .dump_start  (dump_start),
        .dump_done   (dump_done),
        .cycle_count (cycle_count),
        .state_out   (state_out),
        .eop_seen    (eop_seen),
        .timeout     (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] code);
        cmd_valid = 1'b1;
        cmd_code  = code;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_state"}, {29'd0, state_out}, {29'd0, m_state});
        chk({tag, "_count"}, cycle_count, m_count);
        chk({tag, "_eop"}, {31'd0, eop_seen}, {31'd0, m_eop});
        chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, m_timeout});
        chk({tag, "_ready"}, {31'd0, cmd_ready}, {31'd0, (m_state == 3'd0 || m_state == 3'd4)});
    endtask

    // Called just after the edge that entered DUMP; d = cycles before dump_done.
    task automatic do_dump(input int d);
        int pulses = 0;
        chk("dump_state", {29'd0, state_out}, 32'd3);
        chk("dump_enable", {31'd0, pipe_enable}, 32'd0);
        if (dump_start) pulses++;
        for (int i = 0; i < d; i++) begin
            tick();
            if (dump_start) pulses++;
        end
        dump_done = 1'b1;
        tick();
        dump_done = 1'b0;
        if (dump_start) pulses++;
        chk("dump_pulses", pulses, 32'd1);
        m_state = (m_eop || m_timeout) ? 3'd4 : 3'd0;
        check_status("after_dump");
    endtask

    task automatic do_clear();
        send_cmd(CMD_CLEAR);
        m_count = 0; m_eop = 0; m_timeout = 0; m_state = 0;
        chk("clear_reset", {31'd0, pipe_reset}, 32'd1);
        chk("clear_enable", {31'd0, pipe_enable}, 32'd0);
        check_status("clear");
        tick();
        chk("clear_reset_end", {31'd0, pipe_reset}, 32'd0);
    endtask

    task automatic do_step(input logic e, input int d);
        send_cmd(CMD_STEP);
        chk("step_enable", {31'd0, pipe_enable}, 32'd1);
        chk("step_state", {29'd0, state_out}, 32'd2);
        eop_wb = e;
        tick();
        eop_wb = 1'b0;
        m_count = m_count + 1;
        m_eop = e;
        chk("step_enable_end", {31'd0, pipe_enable}, 32'd0);
        chk("step_count", cycle_count, m_count);
        chk("step_eop", {31'd0, eop_seen}, {31'd0, e});
        do_dump(d);
    endtask

    // n = enabled edge at which eop_wb first rises.
    task automatic do_run(input int n, input bit inject, input int d);
        int en = 0;
        bit stopped = 0;
        int stop_n = n;
        logic exp_to = 0;
        send_cmd(CMD_RUN);
        chk("run_enable", {31'd0, pipe_enable}, 32'd1);
        chk("run_state", {29'd0, state_out}, 32'd1);
        chk("run_ready", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 64 && !stopped; i++) begin
            if (pipe_enable) en++;
            eop_wb = (en == n);
            if (inject && i == 1) begin
                cmd_valid = 1'b1;
                cmd_code  = CMD_CLEAR;
            end
            tick();
            eop_wb = 1'b0;
            cmd_valid = 1'b0;
            if (!pipe_enable) stopped = 1;
        end
        chk("run_stopped", {31'd0, stopped}, 32'd1);
`ifdef DEBUG_CTRL_WATCHDOG_EN
        if (m_count < MAXP && (MAXP - m_count) < n) begin
            stop_n = int'(MAXP - m_count);
            exp_to = 1;
        end
`endif
        m_count = m_count + stop_n;
        if (exp_to) m_timeout = 1; else m_eop = 1;
        chk("run_enabled_cycles", en, stop_n);
        chk("run_count", cycle_count, m_count);
        chk("run_eop", {31'd0, eop_seen}, {31'd0, m_eop});
        chk("run_timeout", {31'd0, timeout}, {31'd0, m_timeout});
        do_dump(d);
    endtask

    initial begin
        int op;
        logic [7:0] junk;

        tick();
        tick();
        chk("reset_enable", {31'd0, pipe_enable}, 32'd0);
        chk("reset_preset", {31'd0, pipe_reset}, 32'd0);
        chk("reset_dump_start", {31'd0, dump_start}, 32'd0);
        check_status("reset");
        reset = 1'b0;
        tick();

        do_step(1'b0, 2);
        chk("step_back_idle", {29'd0, state_out}, 32'd0);

        do_clear();
        do_run(7, 1'b0, 1);
        chk("run7_done", {29'd0, state_out}, 32'd4);

        send_cmd(CMD_RUN);
        chk("done_drop_enable", {31'd0, pipe_enable}, 32'd0);
        check_status("done_drop_run");
        do_clear();

`ifdef DEBUG_CTRL_WATCHDOG_EN
        do_run(40, 1'b0, 0);
        chk("wd_timeout", {31'd0, timeout}, 32'd1);
        do_clear();
`endif

        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: do_run($urandom_range(1, 12), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
                1: do_step(1'($urandom_range(0, 1)), $urandom_range(0, 3));
                2: do_clear();
                default: begin
                    junk = 8'($urandom_range(0, 255));
                    if (junk == CMD_RUN || junk == CMD_STEP || junk == CMD_CLEAR) junk = 8'h41;
                    send_cmd(junk);
                    chk("junk_enable", {31'd0, pipe_enable}, 32'd0);
                    check_status("junk");
                end
            endcase
            if (m_state == 3'd4) begin
                send_cmd($urandom_range(0, 1) ? CMD_RUN : CMD_STEP);
                chk("done_drop_enable_r", {31'd0, pipe_enable}, 32'd0);
                check_status("done_drop");
                do_clear();
            end
        end

        // Asynchronous reset in the middle of a run at count 4.
        do_clear();
        send_cmd(CMD_RUN);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_reset_count", cycle_count, 32'd4);
        reset = 1'b1;
        #1;
        m_count = 0; m_eop = 0; m_timeout = 0; m_state = 0;
        chk("async_enable", {31'd0, pipe_enable}, 32'd0);
        chk("async_preset", {31'd0, pipe_reset}, 32'd0);
        chk("async_dump_start", {31'd0, dump_start}, 32'd0);
        check_status("async_reset");
        tick();
        reset = 1'b0;
        send_cmd(8'h41);
        chk("junk41_enable", {31'd0, pipe_enable}, 32'd0);
        check_status("after_41");

        // Reset during DUMP with dump_done left pending afterwards.
        send_cmd(CMD_STEP);
        tick();
        chk("pre_reset_dump_start", {31'd0, dump_start}, 32'd1);
        dump_done = 1'b1;
        reset = 1'b1;
        #1;
        chk("async_dump_start_drop", {31'd0, dump_start}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        dump_done = 1'b0;
        m_count = 0; m_eop = 0; m_timeout = 0; m_state = 0;
        check_status("pending_done_ignored");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
